// File: rtl/barrel_thread_sched.sv
// ============================================================================
// Module   : barrel_thread_sched
// Brief    : Round-robin barrel scheduler. Issues one eligible thread per cycle
//            into a fixed-latency pipeline. Optional perf counters are built
//            only when BARREL_SCHED_PERF_CNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module barrel_thread_sched #(
   parameter int NUM_THREADS = 16,
   parameter int LATENCY     = 5,
   localparam int TID_W      = ($clog2(NUM_THREADS) > 1) ? $clog2(NUM_THREADS) : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_THREADS-1:0] i_thread_en,
   input  logic                   i_start,
   input  logic                   i_stop,
   input  logic                   i_ready,
   output logic                   o_issue_valid,
   output logic [TID_W-1:0]       o_issue_tid,
   output logic                   o_done_valid,
   output logic [TID_W-1:0]       o_done_tid,
   output logic [NUM_THREADS-1:0] o_busy,
   output logic [1:0]             o_state,
   output logic                   o_drained,
   output logic [31:0]            o_issue_cnt,
   output logic [31:0]            o_idle_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam logic [NUM_THREADS-1:0] c_one = NUM_THREADS'(1);
   localparam logic [TID_W:0]         c_nt  = (TID_W+1)'(NUM_THREADS);
   localparam logic [TID_W-1:0]       c_last_tid = TID_W'(NUM_THREADS - 1);

   state_t                           r_state;
   state_t                           w_state_next;
   logic [NUM_THREADS-1:0]           r_busy;
   logic [TID_W-1:0]                 r_last_tid;
   logic [LATENCY-1:0]               r_dl_valid;
   logic [LATENCY-1:0][TID_W-1:0]    r_dl_tid;

   logic [NUM_THREADS-1:0]           w_done_mask;
   logic [NUM_THREADS-1:0]           w_busy_next;
   logic [NUM_THREADS-1:0]           w_elig;
   logic [NUM_THREADS-1:0]           w_rot;
   logic [NUM_THREADS-1:0]           w_issue_mask;
   logic [TID_W-1:0]                 w_rr_start;
   logic [TID_W:0]                   w_rot_back;
   logic [TID_W-1:0]                 w_off;
   logic                             w_sum_c;
   logic [TID_W-1:0]                 w_sum_lo;
   logic [TID_W-1:0]                 w_sel_tid;
   logic                             w_issue;
   logic                             w_dl_empty;
   logic [LATENCY:0]                 w_dl_valid_in;
   logic [LATENCY:0][TID_W-1:0]      w_dl_tid_in;

   // A thread completing this cycle is already free for re-issue.
   assign w_done_mask = o_done_valid ? (c_one << r_dl_tid[LATENCY-1]) : '0;
   assign w_busy_next = r_busy & ~w_done_mask;
   assign w_elig      = i_thread_en & ~w_busy_next;
   assign w_dl_empty  = ~(|r_dl_valid);

   // Rotate the eligible mask so bit 0 is the round-robin starting point.
   assign w_rr_start = (r_last_tid == c_last_tid) ? '0 : r_last_tid + TID_W'(1);
   assign w_rot_back = c_nt - {1'b0, w_rr_start};
   assign w_rot      = (w_elig >> w_rr_start) | (w_elig << w_rot_back);

   always_comb begin
      w_off = '0;
      for (int i = NUM_THREADS - 1; i >= 0; i--) begin
         if (w_rot[i]) begin
            w_off = TID_W'(i);
         end
      end
   end

   // Map the rotated offset back to an absolute tid, modulo NUM_THREADS.
   assign {w_sum_c, w_sum_lo} = {1'b0, w_rr_start} + {1'b0, w_off};
   assign w_sel_tid = (w_sum_c || ({1'b0, w_sum_lo} >= c_nt))
                      ? (w_sum_lo - c_nt[TID_W-1:0]) : w_sum_lo;

   assign w_issue      = (r_state == ST_RUN) && i_ready && !i_stop && (|w_elig);
   assign w_issue_mask = w_issue ? (c_one << w_sel_tid) : '0;

   assign w_dl_valid_in = {r_dl_valid, w_issue};
   assign w_dl_tid_in   = {r_dl_tid, (w_issue ? w_sel_tid : TID_W'(0))};

   always_comb begin
      w_state_next = r_state;
      o_drained    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               w_state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            if (i_stop) begin
               w_state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if ((w_busy_next == '0) && w_dl_empty) begin
               w_state_next = ST_IDLE;
               o_drained    = 1'b1;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_busy     <= '0;
         r_last_tid <= c_last_tid;
         r_dl_valid <= '0;
         r_dl_tid   <= '0;
      end else begin
         r_state    <= w_state_next;
         r_busy     <= w_busy_next | w_issue_mask;
         r_dl_valid <= w_dl_valid_in[LATENCY-1:0];
         r_dl_tid   <= w_dl_tid_in[LATENCY-1:0];
         if (w_issue) begin
            r_last_tid <= w_sel_tid;
         end
      end
   end

   assign o_issue_valid = w_issue;
   assign o_issue_tid   = w_issue ? w_sel_tid : '0;
   assign o_done_valid  = r_dl_valid[LATENCY-1];
   assign o_done_tid    = r_dl_valid[LATENCY-1] ? r_dl_tid[LATENCY-1] : '0;
   assign o_busy        = r_busy;
   assign o_state       = r_state;

`ifdef BARREL_SCHED_PERF_CNT_EN
   logic [31:0] r_issue_cnt;
   logic [31:0] r_idle_cnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_issue_cnt <= '0;
         r_idle_cnt  <= '0;
      end else begin
         if (w_issue) begin
            r_issue_cnt <= r_issue_cnt + 32'd1;
         end
         if ((r_state == ST_RUN) && !w_issue) begin
            r_idle_cnt <= r_idle_cnt + 32'd1;
         end
      end
   end

   assign o_issue_cnt = r_issue_cnt;
   assign o_idle_cnt  = r_idle_cnt;
`else
   assign o_issue_cnt = '0;
   assign o_idle_cnt  = '0;
`endif

endmodule

`default_nettype wire

// File: doc/barrel_thread_sched.md
BARREL_THREAD_SCHED -- requirements
Module: barrel_thread_sched

Interface
REQ-001 SHALL have parameter NUM_THREADS, default 16: number of hardware threads; legal values 2..64.
REQ-002 SHALL have parameter LATENCY, default 5: cycles from issue to completion; legal values 1..32.
REQ-003 SHALL derive localparam TID_W = max(1, $clog2(NUM_THREADS)).
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-low reset (0 = reset).
REQ-006 SHALL have port i_thread_en  in  NUM_THREADS  per-thread enable mask.
REQ-007 SHALL have port i_start  in  1  single-cycle pulse; IDLE -> RUN.
REQ-008 SHALL have port i_stop  in  1  single-cycle pulse; RUN -> DRAIN.
REQ-009 SHALL have port i_ready  in  1  downstream pipeline accepts an issue this cycle.
REQ-010 SHALL have port o_issue_valid  out  1  issue slot carries a thread this cycle.
REQ-011 SHALL have port o_issue_tid  out  TID_W  issued thread id; 0 when o_issue_valid=0.
REQ-012 SHALL have port o_done_valid  out  1  a thread completes this cycle.
REQ-013 SHALL have port o_done_tid  out  TID_W  completing thread id; 0 when o_done_valid=0.
REQ-014 SHALL have port o_busy  out  NUM_THREADS  per-thread in-flight mask.
REQ-015 SHALL have port o_state  out  2  0=IDLE, 1=RUN, 2=DRAIN.
REQ-016 SHALL have port o_drained  out  1  one-cycle pulse on DRAIN -> IDLE.
REQ-017 SHALL have port o_issue_cnt  out  32  issue counter (see Configuration).
REQ-018 SHALL have port o_idle_cnt  out  32  idle-slot counter (see Configuration).

Function
REQ-019 Eligible mask SHALL be i_thread_en & ~busy_next, where busy_next is busy with the bit of the thread completing this cycle already cleared; a completing thread is re-issuable in the same cycle.
REQ-020 o_issue_valid SHALL be combinational: 1 iff state=RUN, i_ready=1 and eligible != 0.
REQ-021 Selection SHALL be round-robin: first eligible tid searching upward from (last_tid+1) mod NUM_THREADS, wrapping; last_tid updates only on an issue.
REQ-022 On an issue, busy[tid] SHALL be set at the next edge and a {valid=1, tid} token SHALL enter an internal LATENCY-stage delay line.
REQ-023 The delay line SHALL advance every cycle regardless of i_ready or state; o_done_valid/o_done_tid SHALL be its last stage, asserted exactly LATENCY cycles after the issue cycle.
REQ-024 On o_done_valid, busy[o_done_tid] SHALL clear at the next edge unless the same tid is re-issued that cycle, in which case busy stays 1.
REQ-025 FSM: IDLE --i_start--> RUN; RUN --i_stop--> DRAIN; DRAIN --(busy_next==0 and delay line empty)--> IDLE with o_drained=1 for that cycle.
REQ-026 i_start outside IDLE and i_stop outside RUN SHALL be ignored; simultaneous i_start and i_stop in IDLE SHALL give RUN.
REQ-027 No issue SHALL occur in IDLE or DRAIN, nor in the cycle i_stop is sampled.
REQ-028 Clearing i_thread_en for an in-flight thread SHALL NOT cancel it; its token still completes.
REQ-029 If DRAIN is entered with nothing in flight, DRAIN SHALL last exactly one cycle.

Reset
REQ-030 While reset=0 at a rising edge: state=IDLE, busy=0, delay line valid bits=0, last_tid=NUM_THREADS-1 (first issue is tid 0), counters=0.
REQ-031 After reset, all outputs SHALL be 0.
REQ-032 Reset mid-operation SHALL discard all in-flight tokens; no o_done_valid for pre-reset issues.

Configuration
REQ-033 Macro BARREL_SCHED_PERF_CNT_EN defined: o_issue_cnt +1 per issue; o_idle_cnt +1 per RUN cycle with o_issue_valid=0; both wrap modulo 2^32.
REQ-034 Macro undefined: both counter ports tied to 0 and no counter flops instantiated; all other behaviour identical.

Verification
REQ-035 NUM_THREADS=4, LATENCY=5, all enabled, i_ready=1, i_start -> issues tid 0,1,2,3, then no issue until tid 0 done at cycle 5 and re-issued that same cycle; steady state is 4 issues every 5 cycles.
REQ-036 NUM_THREADS=4, LATENCY=2, i_thread_en=4'b1010 -> issue order 1,3,1,3,..., o_busy never sets bits 0 or 2.
REQ-037 i_ready=0 for 3 cycles mid-run -> no issues, o_idle_cnt +3 (macro on), delay line keeps draining, round-robin resumes at next tid.
REQ-038 i_stop with 3 threads in flight -> DRAIN, no issues, o_drained pulses the cycle the last token's busy clears, then state=IDLE.
REQ-039 reset=0 while tokens in flight -> after release all outputs 0, no o_done_valid, first issue after i_start is tid 0.
REQ-040 Macro undefined, 100 issue cycles -> o_issue_cnt=0, o_idle_cnt=0; macro defined -> o_issue_cnt=100.
